// File: rtl/ifetch_unit_pkg.sv
// Shared fetch-stage encodings: FSM state values, reset PC and the canonical NOP.
// Imported by the fetch unit and by anything that needs to speak its encodings.
package ifetch_unit_pkg;

   typedef enum logic [1:0] {
      IF_S_REQ  = 2'd0,
      IF_S_WAIT = 2'd1,
      IF_S_OUT  = 2'd2
   } if_state_e;

   localparam logic [31:0] IF_RESET_PC = 32'h0000_0000;

   // Canonical addi x0,x0,0 for decode-side bubble insertion.
   localparam logic [31:0] INST_NOP = 32'h0000_0013;

   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master)
// and the instruction memory (slave).
interface ifetch_unit_if;

   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;

   modport master (
      output imem_req_valid,
      output imem_req_addr,
      input  imem_req_ready,
      input  imem_rsp_valid,
      input  imem_rsp_data
   );

   modport slave (
      input  imem_req_valid,
      input  imem_req_addr,
      output imem_req_ready,
      output imem_rsp_valid,
      output imem_rsp_data
   );

endinterface

// File: rtl/ifetch_unit.sv
// Instruction-fetch front end: owns the PC, keeps one imem request in flight,
// buffers one instruction for decode and squashes wrong-path fetches on redirect.
module ifetch_unit
   import ifetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC = IF_RESET_PC,
   parameter int unsigned PC_STEP  = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                redirect_valid,
   input  logic [31:0]         redirect_pc,
   ifetch_unit_if.master       imem,
   output logic                inst_valid,
   input  logic                inst_ready,
   output logic [31:0]         inst_pc,
   output logic [31:0]         inst_data,
   output logic                misalign_err,
   output logic [31:0]         fetch_count
);

   localparam logic [31:0] PC_INC = 32'(PC_STEP);

   if_state_e   state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        discard_q, discard_d;
   logic        valid_q, valid_d;
   logic [31:0] ipc_q, ipc_d;
   logic [31:0] idata_q, idata_d;
   logic [31:0] count_q, count_d;
   logic        mis_q;
   logic [31:0] redirect_aligned;

   assign redirect_aligned = align_pc(redirect_pc);

   assign imem.imem_req_valid = (state_q == IF_S_REQ) && !rst;
   assign imem.imem_req_addr  = pc_q;

   assign inst_valid   = valid_q;
   assign inst_pc      = ipc_q;
   assign inst_data    = idata_q;
   assign misalign_err = mis_q;
   assign fetch_count  = count_q;

   always_comb begin
      // NOTE: every *_d gets its hold value first so no path through the case can infer a latch.
      state_d   = state_q;
      pc_d      = pc_q;
      discard_d = discard_q;
      valid_d   = valid_q;
      ipc_d     = ipc_q;
      idata_d   = idata_q;
      count_d   = count_q;

      unique case (state_q)
         IF_S_REQ: begin
            if (redirect_valid) begin
               pc_d = redirect_aligned;
               // The old address was taken this cycle; its data must be dropped.
               if (imem.imem_req_ready) begin
                  state_d   = IF_S_WAIT;
                  discard_d = 1'b1;
               end
            end else if (imem.imem_req_ready) begin
               state_d   = IF_S_WAIT;
               discard_d = 1'b0;
            end
         end

         IF_S_WAIT: begin
            if (imem.imem_rsp_valid) begin
               if (discard_q || redirect_valid) begin
                  discard_d = 1'b0;
                  state_d   = IF_S_REQ;
                  if (redirect_valid) pc_d = redirect_aligned;
               end else begin
                  idata_d = imem.imem_rsp_data;
                  ipc_d   = pc_q;
                  pc_d    = pc_q + PC_INC;
                  valid_d = 1'b1;
                  state_d = IF_S_OUT;
               end
            end else if (redirect_valid) begin
               pc_d      = redirect_aligned;
               discard_d = 1'b1;
            end
         end

         IF_S_OUT: begin
            // Redirect wins over a same-cycle decode handshake: the instruction is squashed.
            if (redirect_valid) begin
               valid_d = 1'b0;
               pc_d    = redirect_aligned;
               state_d = IF_S_REQ;
            end else if (inst_ready) begin
               valid_d = 1'b0;
               count_d = count_q + 32'd1;
               state_d = IF_S_REQ;
            end
         end

         default: state_d = IF_S_REQ;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: registered state uses non-blocking assignments so all flops update together.
      if (rst) begin
         state_q   <= IF_S_REQ;
         pc_q      <= RESET_PC;
         discard_q <= 1'b0;
         valid_q   <= 1'b0;
         ipc_q     <= 32'h0;
         idata_q   <= 32'h0;
         count_q   <= 32'h0;
         mis_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         discard_q <= discard_d;
         valid_q   <= valid_d;
         ipc_q     <= ipc_d;
         idata_q   <= idata_d;
         count_q   <= count_d;
         mis_q     <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      end
   end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed scenarios then randomized traffic,
// checked against a transaction-level model of the fetch stream.
module tb_ifetch_unit;
   import ifetch_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        inst_ready = 1'b0;
   logic        inst_valid;
   logic [31:0] inst_pc;
   logic [31:0] inst_data;
   logic        misalign_err;
   logic [31:0] fetch_count;

   ifetch_unit_if bus();

   ifetch_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem           (bus),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_pc        (inst_pc),
      .inst_data      (inst_data),
      .misalign_err   (misalign_err),
      .fetch_count    (fetch_count)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;
   int cyc     = 0;

   // Reference model: next address the front end should fetch, the instruction
   // decode should be holding, and the memory's single in-flight request.
   logic [31:0] exp_pc = 32'h0;
   logic [31:0] exp_ipc = 32'h0;
   logic [31:0] exp_idata = 32'h0;
   logic [31:0] exp_count = 32'h0;
   bit          exp_valid = 1'b0;
   bit          exp_mis = 1'b0;
   bit          pend = 1'b0;
   bit          live = 1'b0;
   logic [31:0] pend_addr = 32'h0;
   int          pend_wait = 0;
   int          lat_lo = 1;
   int          lat_hi = 1;
   bit          poison = 1'b0;
   bit          stale_rsp = 1'b0;

   bit          ev_hs = 1'b0;
   bit          ev_rise = 1'b0;
   bit          prev_valid = 1'b0;
   logic [31:0] last_hs_addr = 32'h0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[7:0], a[31:8]} ^ 32'h5A5A_3C3C;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic tick(input bit r, input bit rv, input logic [31:0] rp, input bit ir, input bit mr);
      bit rsp_now;
      bit hs;
      bit exp_req;
      @(negedge clk);
      cyc++;
      rst                = r;
      redirect_valid     = rv;
      redirect_pc        = rp;
      inst_ready         = ir;
      bus.imem_req_ready = mr;
      rsp_now = 1'b0;
      if (pend && !r) begin
         if (pend_wait > 0) pend_wait--;
         rsp_now = (pend_wait == 0);
      end
      bus.imem_rsp_valid = rsp_now || stale_rsp;
      if (stale_rsp || (rsp_now && poison)) bus.imem_rsp_data = 32'hDEAD_BEEF;
      else if (rsp_now)                     bus.imem_rsp_data = mem_word(pend_addr);
      else                                  bus.imem_rsp_data = $urandom;
      #1;
      exp_req = !r && !pend && !exp_valid;
      check("req_valid", bus.imem_req_valid, exp_req);
      if (exp_req) check("req_addr", bus.imem_req_addr, exp_pc);
      hs = bus.imem_req_valid && mr;
      ev_hs = hs;
      if (hs) last_hs_addr = bus.imem_req_addr;

      if (r) begin
         exp_pc = 32'h0; exp_ipc = 32'h0; exp_idata = 32'h0; exp_count = 32'h0;
         exp_valid = 1'b0; exp_mis = 1'b0; pend = 1'b0; live = 1'b0;
      end else begin
         if (hs) begin
            pend = 1'b1; live = 1'b1; pend_addr = exp_pc;
            pend_wait = $urandom_range(lat_hi, lat_lo);
         end
         if (rsp_now) begin
            pend = 1'b0;
            poison = 1'b0;
            if (live && !rv) begin
               exp_valid = 1'b1;
               exp_ipc   = pend_addr;
               exp_idata = mem_word(pend_addr);
               exp_pc    = pend_addr + 32'd4;
            end
         end else if (exp_valid && ir && !rv) begin
            exp_valid = 1'b0;
            exp_count = exp_count + 32'd1;
         end
         if (rv) begin
            exp_pc    = {rp[31:2], 2'b00};
            live      = 1'b0;
            exp_valid = 1'b0;
         end
         exp_mis = rv && (rp[1:0] != 2'b00);
      end

      @(posedge clk);
      #1;
      check("inst_valid", inst_valid, exp_valid);
      if (exp_valid || r) begin
         check("inst_pc", inst_pc, exp_ipc);
         check("inst_data", inst_data, exp_idata);
      end
      check("fetch_count", fetch_count, exp_count);
      check("misalign_err", misalign_err, exp_mis);
      ev_rise = inst_valid && !prev_valid;
      prev_valid = inst_valid;
   endtask

   // Idle-input ticks until a request handshake (want_hs) or a new decode instruction.
   task automatic run_to(input bit want_hs, input bit ir, input string tag);
      int n = 0;
      do begin
         tick(1'b0, 1'b0, 32'h0, ir, 1'b1);
         n++;
      end while (!(want_hs ? ev_hs : ev_rise) && n < 40);
      check(tag, want_hs ? ev_hs : ev_rise, 1'b1);
   endtask

   initial begin
      int          nr;
      int          rise_cyc[3];
      logic [31:0] rise_pc[3];
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'h0;

      repeat (2) tick(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);

      // Back-to-back fetches: 1-cycle memory, decode always ready.
      nr = 0;
      for (int i = 0; i < 9; i++) begin
         tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
         if (ev_rise) begin
            if (nr < 3) begin
               rise_cyc[nr] = cyc;
               rise_pc[nr]  = inst_pc;
            end
            nr++;
         end
      end
      check("tp_rises", nr, 3);
      if (nr >= 3) begin
         for (int i = 0; i < 3; i++) check("tp_pc", rise_pc[i], 32'(i * 4));
         check("tp_gap1", rise_cyc[1] - rise_cyc[0], 3);
         check("tp_gap2", rise_cyc[2] - rise_cyc[1], 3);
      end
      check("tp_count", fetch_count, 32'd3);

      // Decode backpressure for 5 cycles.
      run_to(1'b0, 1'b0, "bp_reach");
      for (int i = 0; i < 5; i++) begin
         tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
         check("bp_valid", inst_valid, 1'b1);
         check("bp_pc", inst_pc, 32'h0000_000C);
         check("bp_data", inst_data, mem_word(32'h0000_000C));
      end

      // Redirect while waiting; the poisoned late response must be dropped.
      lat_lo = 3; lat_hi = 3;
      poison = 1'b1;
      tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      tick(1'b0, 1'b1, 32'h0000_0100, 1'b1, 1'b1);
      run_to(1'b1, 1'b1, "rw_reach");
      check("rw_addr", last_hs_addr, 32'h0000_0100);
      lat_lo = 1; lat_hi = 1;
      run_to(1'b0, 1'b0, "rw_deliv");
      check("rw_pc", inst_pc, 32'h0000_0100);
      check("rw_data", inst_data, mem_word(32'h0000_0100));

      // Redirect in the output stage together with a decode handshake.
      tick(1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b1);
      check("ro_valid", inst_valid, 1'b0);
      check("ro_count", fetch_count, 32'd4);
      run_to(1'b1, 1'b1, "ro_reach");
      check("ro_addr", last_hs_addr, 32'h0000_0200);

      // Misaligned redirect target.
      tick(1'b0, 1'b1, 32'h0000_0106, 1'b1, 1'b1);
      check("mis_hi", misalign_err, 1'b1);
      tick(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      check("mis_lo", misalign_err, 1'b0);
      run_to(1'b0, 1'b0, "mis_deliv");
      check("mis_pc", inst_pc, 32'h0000_0104);

      // PC wrap from the top of the address space.
      tick(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1);
      run_to(1'b0, 1'b0, "wr_deliv");
      check("wr_pc", inst_pc, 32'hFFFF_FFFC);
      lat_lo = 4; lat_hi = 4;
      tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      run_to(1'b1, 1'b1, "wr_hs");
      check("wr_addr", last_hs_addr, 32'h0000_0000);

      // Reset with a request outstanding; a stale response afterwards is ignored.
      tick(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
      tick(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
      check("rst_valid", inst_valid, 1'b0);
      check("rst_count", fetch_count, 32'd0);
      stale_rsp = 1'b1;
      tick(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      stale_rsp = 1'b0;
      check("stale_valid", inst_valid, 1'b0);
      lat_lo = 1; lat_hi = 1;
      run_to(1'b1, 1'b1, "rst_hs");
      check("rst_addr", last_hs_addr, 32'h0000_0000);

      // Randomized traffic.
      lat_lo = 1; lat_hi = 4;
      for (int i = 0; i < 3000; i++) begin
         bit          r, rv, ir, mr;
         logic [31:0] rp;
         r  = ($urandom % 256) == 0;
         rv = ($urandom % 8) == 0;
         ir = ($urandom % 4) != 0;
         mr = ($urandom % 3) != 0;
         if (($urandom % 4) == 0) rp = 32'hFFFF_FFF0 | 32'($urandom % 16);
         else                     rp = $urandom & 32'h0000_0FFF;
         tick(r, rv, rp, ir, mr);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
